// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the image-RAM port arbiter.
package ram_arb_pkg;

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam int REQ_VIEW   = 0;
   localparam int REQ_ENGINE = 1;
   localparam int REQ_LOAD   = 2;

   // Requester index width; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter: request/lock/write in, grant/read return out.
interface ram_port_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]             req;
   logic [N_REQ-1:0]             lock;
   logic [N_REQ-1:0]             we;
   logic [N_REQ-1:0][ADDR_W-1:0] addr;
   logic [N_REQ-1:0][DATA_W-1:0] wdata;
   logic [N_REQ-1:0]             gnt;
   logic [N_REQ-1:0]             rvalid;
   logic [DATA_W-1:0]            rdata;

   modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   int j;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            idx       = IDX_W'(j);
            onehot[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port image RAM among N_REQ requesters: round-robin grant,
// bounded burst lock, and tagged read-data return to the issuing requester.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 64
) (
   input  logic              clk,
   input  logic              rst,
   ram_port_arbiter_if.slave bus,
   output logic [ADDR_W-3:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam int IDX_W = idx_w(N_REQ);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx, owner, owner_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic [N_REQ-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             rd_issue;
   logic             addr_lsb_unused;

   logic [RD_LAT-1:0] vld_p;
   logic [IDX_W-1:0]  tag_p [RD_LAT];

   rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         owner <= owner_nx;
         cnt   <= cnt_nx;
      end
   end

   // Grant and next state; reset masks every grant so nothing reaches the RAM.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      owner_nx = owner;
      cnt_nx   = cnt;
      gnt_any  = 1'b0;
      gnt_idx  = owner;
      bus.gnt  = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_any = 1'b1;
                  gnt_idx = pick_idx;
                  bus.gnt = pick_oh;
                  ptr_nx  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                  if (bus.lock[pick_idx] && MAX_LOCK > 1) begin
                     state_nx = LOCKED;
                     owner_nx = pick_idx;
                     cnt_nx   = CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (bus.req[owner]) begin
                  gnt_any          = 1'b1;
                  bus.gnt[owner]   = 1'b1;
                  if (!bus.lock[owner] || cnt >= CNT_LAST) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      ram_we          = gnt_any & bus.we[gnt_idx];
      ram_addr        = gnt_any ? bus.addr[gnt_idx][ADDR_W-1:2] : '0;
      ram_wdata       = gnt_any ? bus.wdata[gnt_idx] : '0;
      rd_issue        = gnt_any & ~bus.we[gnt_idx];
      addr_lsb_unused = ^bus.addr[gnt_idx][1:0];
   end

   // Read-tag pipeline p0..p(RD_LAT-1); tail lines up with ram_rdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= rd_issue;
         for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_p[0] <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
   end

   always_comb begin
      bus.rvalid = '0;
      if (vld_p[RD_LAT-1] && !rst) bus.rvalid[tag_p[RD_LAT-1]] = 1'b1;
      bus.rdata = ram_rdata;
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (RD_LAT=1/MAX_LOCK=64 and RD_LAT=3/MAX_LOCK=4)
// share directed stimulus; a queue-style model and literal expectations check both.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   localparam int NR   = 3;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int LAT0 = 1;
   localparam int LAT1 = 3;
   localparam int MLK0 = 64;
   localparam int MLK1 = 4;

   logic clk = 1'b0;
   logic rst;
   logic [NR-1:0]         req, lock, we;
   logic [NR-1:0][AW-1:0] addr, na;
   logic [NR-1:0][DW-1:0] wdata, nwd;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
   ram_port_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.req = req;   assign bus1.req = req;
   assign bus0.lock = lock; assign bus1.lock = lock;
   assign bus0.we = we;     assign bus1.we = we;
   assign bus0.addr = addr; assign bus1.addr = addr;
   assign bus0.wdata = wdata; assign bus1.wdata = wdata;

   logic [1:0][AW-3:0] ram_addr;
   logic [1:0]         ram_we;
   logic [1:0][DW-1:0] ram_wdata, ram_rdata;

   ram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT0), .MAX_LOCK(MLK0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

   ram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1), .MAX_LOCK(MLK1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

   logic [1:0][NR-1:0] gnt_o, rv_o;
   logic [1:0][DW-1:0] rd_o;
   assign gnt_o[0] = bus0.gnt;  assign gnt_o[1] = bus1.gnt;
   assign rv_o[0] = bus0.rvalid; assign rv_o[1] = bus1.rvalid;
   assign rd_o[0] = bus0.rdata; assign rd_o[1] = bus1.rdata;

   // RAM macros: read-first, data appears RD_LAT cycles after the issuing edge
   logic [DW-1:0] mem   [2][256];
   logic [DW-1:0] rpipe [2][4];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ram_we[d]) mem[d][ram_addr[d][7:0]] <= ram_wdata[d];
         rpipe[d][0] <= mem[d][ram_addr[d][7:0]];
         for (int s = 1; s < 4; s++) rpipe[d][s] <= rpipe[d][s-1];
      end
   end
   assign ram_rdata[0] = rpipe[0][LAT0-1];
   assign ram_rdata[1] = rpipe[1][LAT1-1];

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
      end
   endtask

   // Behavioural model: owner (-1 = none), rr pointer, lock count, and a
   // per-cycle schedule of expected read returns.
   logic [DW-1:0] mmem [2][256];
   int own [2];
   int ptr [2];
   int cnt [2];
   int lat [2];
   int mlk [2];
   logic          sv   [2][8];
   int            st   [2][8];
   logic [DW-1:0] sdat [2][8];
   int cyc = 0;

   int            eg, slot, ws;
   logic [NR-1:0] e_gnt, e_rv;
   logic          e_we;
   logic [AW-3:0] e_addr;
   logic [DW-1:0] e_wd;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         eg = -1;
         if (!rst) begin
            if (own[d] < 0) begin
               for (int i = 0; i < NR; i++)
                  if (eg < 0 && req[(ptr[d] + i) % NR]) eg = (ptr[d] + i) % NR;
            end else if (req[own[d]]) begin
               eg = own[d];
            end
         end
         e_gnt = '0; e_we = 1'b0; e_addr = '0; e_wd = '0;
         if (eg >= 0) begin
            e_gnt  = NR'(1 << eg);
            e_we   = we[eg];
            e_addr = addr[eg][AW-1:2];
            e_wd   = wdata[eg];
         end
         slot = cyc % 8;
         e_rv = '0;
         if (!rst && sv[d][slot]) e_rv = NR'(1 << st[d][slot]);

         chk("m_gnt", d, 64'(gnt_o[d]), 64'(e_gnt));
         chk("m_ram_we", d, 64'(ram_we[d]), 64'(e_we));
         chk("m_ram_addr", d, 64'(ram_addr[d]), 64'(e_addr));
         chk("m_ram_wdata", d, 64'(ram_wdata[d]), 64'(e_wd));
         chk("m_rvalid", d, 64'(rv_o[d]), 64'(e_rv));
         if (e_rv != '0) chk("m_rdata", d, 64'(rd_o[d]), 64'(sdat[d][slot]));

         if (rst) begin
            own[d] = -1; ptr[d] = 0; cnt[d] = 0;
            for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
         end else begin
            sv[d][slot] = 1'b0;
            if (eg >= 0) begin
               ws = (addr[eg] >> 2) & 255;
               if (we[eg]) begin
                  mmem[d][ws] = wdata[eg];
               end else begin
                  sv[d][(cyc + lat[d]) % 8]   = 1'b1;
                  st[d][(cyc + lat[d]) % 8]   = eg;
                  sdat[d][(cyc + lat[d]) % 8] = mmem[d][ws];
               end
               if (own[d] < 0) begin
                  ptr[d] = (eg + 1) % NR;
                  if (lock[eg] && mlk[d] > 1) begin own[d] = eg; cnt[d] = 1; end
               end else if (!lock[eg]) begin
                  own[d] = -1;
               end else begin
                  cnt[d]++;
                  if (cnt[d] >= mlk[d]) own[d] = -1;
               end
            end else if (own[d] >= 0) begin
               own[d] = -1;
            end
         end
      end
      cyc++;
   end

   task automatic drive(input logic r_rst, input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic [NR-1:0] w);
      @(posedge clk); #1;
      rst = r_rst; req = r; lock = l; we = w; addr = na; wdata = nwd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
   endtask

   logic [NR-1:0] rr_exp   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [NR-1:0] lk_exp0  [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
   logic [NR-1:0] lk_exp1  [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      lat[0] = LAT0; lat[1] = LAT1; mlk[0] = MLK0; mlk[1] = MLK1;
      for (int d = 0; d < 2; d++) begin
         own[d] = -1; ptr[d] = 0; cnt[d] = 0;
         for (int s = 0; s < 8; s++) begin sv[d][s] = 1'b0; st[d][s] = 0; sdat[d][s] = '0; end
         for (int i = 0; i < 256; i++) begin
            mem[d][i]  = 32'h5A00_0000 + i;
            mmem[d][i] = 32'h5A00_0000 + i;
         end
         mem[d][2]  = 32'hDEADBEEF;
         mmem[d][2] = 32'hDEADBEEF;
      end
      na = '0; nwd = '0;
      rst = 1'b1; req = '1; lock = '0; we = '0; addr = '0; wdata = '0;

      // Reset with every requester asking
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 3'b111, '0, '0);
         for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", d, 64'(gnt_o[d]), 64'd0);
            chk("rst_rvalid", d, 64'(rv_o[d]), 64'd0);
            chk("rst_ram_we", d, 64'(ram_we[d]), 64'd0);
         end
      end

      // Single read of word 2
      na[REQ_VIEW] = 16'h0008;
      drive(1'b0, 3'b001, '0, '0);
      for (int d = 0; d < 2; d++) begin
         chk("single_gnt", d, 64'(gnt_o[d]), 64'b001);
         chk("single_addr", d, 64'(ram_addr[d]), 64'd2);
      end
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, '0, '0, '0);
         if (k == LAT0) begin
            chk("single_rvalid", 0, 64'(rv_o[0]), 64'b001);
            chk("single_rdata", 0, 64'(rd_o[0]), 64'hDEADBEEF);
         end
         if (k == LAT1) begin
            chk("single_rvalid", 1, 64'(rv_o[1]), 64'b001);
            chk("single_rdata", 1, 64'(rd_o[1]), 64'hDEADBEEF);
         end
      end

      // Round robin, all reading distinct words 16..18
      drive(1'b1, '0, '0, '0);
      for (int i = 0; i < NR; i++) na[i] = AW'(4 * (16 + i));
      for (int j = 0; j < 6; j++) begin
         drive(1'b0, 3'b111, '0, '0);
         chk("rr_gnt", 0, 64'(gnt_o[0]), 64'(rr_exp[j]));
         chk("rr_gnt", 1, 64'(gnt_o[1]), 64'(rr_exp[j]));
         if (j >= 1) begin
            chk("rr_tag", 0, 64'(rv_o[0]), 64'(rr_exp[j-1]));
            chk("rr_rdata", 0, 64'(rd_o[0]), 64'(32'h5A00_0010 + (j - 1) % 3));
         end
      end
      idle(3);

      // Burst lock by the engine (writes); dut1 times out after 4 grants
      na[REQ_VIEW] = AW'(4 * 16);
      na[REQ_LOAD] = AW'(4 * 18);
      for (int c = 1; c <= 8; c++) begin
         na[REQ_ENGINE]  = AW'(4 * (32 + c));
         nwd[REQ_ENGINE] = 32'h1000_0000 + c;
         drive(1'b0, (c == 1) ? 3'b010 : 3'b111, (c <= 5) ? 3'b010 : 3'b000, 3'b010);
         chk("lock_gnt", 0, 64'(gnt_o[0]), 64'(lk_exp0[c-1]));
         chk("lock_timeout_gnt", 1, 64'(gnt_o[1]), 64'(lk_exp1[c-1]));
         if (c == 1) begin
            chk("lock_wr_we", 0, 64'(ram_we[0]), 64'd1);
            chk("lock_wr_data", 0, 64'(ram_wdata[0]), 64'h1000_0001);
         end
      end
      idle(4);

      // Read back a word written during the burst
      na[REQ_VIEW] = AW'(4 * 34);
      drive(1'b0, 3'b001, '0, '0);
      drive(1'b0, '0, '0, '0);
      chk("wr_readback", 0, 64'(rd_o[0]), 64'h1000_0002);
      idle(3);

      // Lock released by dropping req
      drive(1'b0, 3'b100, 3'b100, '0);
      chk("drop_first", 0, 64'(gnt_o[0]), 64'b100);
      chk("drop_first", 1, 64'(gnt_o[1]), 64'b100);
      drive(1'b0, 3'b001, '0, '0);
      chk("drop_hold", 0, 64'(gnt_o[0]), 64'b000);
      chk("drop_hold", 1, 64'(gnt_o[1]), 64'b000);
      drive(1'b0, 3'b001, '0, '0);
      chk("drop_next", 0, 64'(gnt_o[0]), 64'b001);
      chk("drop_next", 1, 64'(gnt_o[1]), 64'b001);
      idle(3);

      // Reset with reads in flight
      drive(1'b0, 3'b111, '0, '0);
      drive(1'b0, 3'b111, '0, '0);
      drive(1'b1, 3'b111, '0, '0);
      chk("midrst_rvalid", 1, 64'(rv_o[1]), 64'd0);
      chk("midrst_gnt", 1, 64'(gnt_o[1]), 64'd0);
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, '0, '0, '0);
         chk("midrst_flush", 1, 64'(rv_o[1]), 64'd0);
      end
      drive(1'b0, 3'b111, '0, '0);
      chk("postrst_gnt", 0, 64'(gnt_o[0]), 64'b001);
      chk("postrst_gnt", 1, 64'(gnt_o[1]), 64'b001);
      idle(4);

      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
